// File: rtl/demux_1n_stream.sv
// demux_1n_stream: 1-to-N streaming demultiplexer with one registered output
// slot per channel. Each accepted input beat goes to the slot addressed by
// in_sel or to every slot at once in broadcast mode. Beats addressed past the
// last channel are sunk and flagged on err_sel.
// Optional per-channel accepted-beat counters: define DEMUX_STATS_EN.

// One output slot: a single-entry register with its own valid bit.
module demux_1n_stream_slot #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] din,
  input  logic          ready,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic          free,
  output logic [15:0]   cnt
);

  // The slot can take a new beat when it is empty or being drained now.
  assign free = !valid | ready;

  // Slot register: a reload wins over a drain so a busy channel streams at 1 beat/clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= din;
    end else if (valid & ready) begin
      valid <= 1'b0;
    end
  end

`ifdef DEMUX_STATS_EN
  // Saturating count of beats loaded into this slot; only reset clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    cnt <= '0;
    else if (load && cnt != '1) cnt <= cnt + 16'd1;
  end
`else
  assign cnt = '0;
`endif

endmodule

module demux_1n_stream #(
  parameter int DW    = 8,
  parameter int N     = 8,
  parameter int SEL_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DW-1:0]     in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_bcast,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [N*DW-1:0]   out_data,
  output logic [N-1:0]      out_valid,
  input  logic [N-1:0]      out_ready,
  output logic              err_sel,
  output logic [N*16-1:0]   stat_cnt
);

  if (N < 2 || N > (1 << SEL_W)) begin : g_bad_cfg
    $error("demux_1n_stream: need 2 <= N <= 2**SEL_W");
  end

  typedef struct packed {
    logic [DW-1:0]    data;
    logic [SEL_W-1:0] sel;
    logic             bcast;
  } req_t;

  req_t                          req;
  logic [31:0]                   sel_ext;
  logic                          in_range;
  logic                          accept;
  logic [N-1:0]                  free;
  logic [(1<<SEL_W)-1:0]         free_pad;
  logic [N-1:0]                  load;
  logic [N-1:0][DW-1:0]          slot_data;
  logic [N-1:0][15:0]            slot_cnt;

  assign req      = '{data: in_data, sel: in_sel, bcast: in_bcast};
  assign sel_ext  = 32'(req.sel);
  assign in_range = sel_ext < 32'(N);

  // Pad the free vector out to the full select range so in_sel can index it directly.
  always_comb begin
    free_pad        = '0;
    free_pad[N-1:0] = free;
  end

  // Broadcast waits for every slot (never partial); out-of-range beats are always sunk.
  always_comb begin
    in_ready = 1'b1;
    if (req.bcast)     in_ready = &free;
    else if (in_range) in_ready = free_pad[req.sel];
  end

  assign accept = in_valid & in_ready;

  for (genvar i = 0; i < N; i++) begin : g_lane
    assign load[i] = accept & (req.bcast | (in_range & (sel_ext == 32'(i))));

    demux_1n_stream_slot #(.DW(DW)) u_slot (
      .clk   (clk),
      .rst   (rst),
      .load  (load[i]),
      .din   (req.data),
      .ready (out_ready[i]),
      .valid (out_valid[i]),
      .data  (slot_data[i]),
      .free  (free[i]),
      .cnt   (slot_cnt[i])
    );
  end

  assign out_data = slot_data;
  assign stat_cnt = slot_cnt;

  // One-cycle flag for a dropped beat whose select names no channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_sel <= 1'b0;
    else     err_sel <= accept & !req.bcast & !in_range;
  end

endmodule
